alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
- Execute-to-writeback stage directly downstream of the 32-bit ALU.
- Captures the ALU's combinational Result/Zero/Overflow/CarryOut together with the instruction's destination and trap enable.
- Sanitises the flags per ALUop, converts signed overflow into an exception, and holds results in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Decouples ALU timing from register-file writeback; counts overflow exceptions for debug.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, destination register index width.
- CNT_WIDTH, 16, width of the saturating exception counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU outputs and sideband valid this cycle.
- in_ready  out  1  buffer can accept; registered.
- in_op  in  3  ALUop of the instruction (AND 000, OR 001, ADD 010, SUB 110, SLT 111).
- in_result  in  DATA_WIDTH  ALU Result.
- in_zero  in  1  ALU Zero.
- in_overflow  in  1  ALU Overflow.
- in_carryout  in  1  ALU CarryOut.
- in_dest  in  REG_ADDR_WIDTH  destination register.
- in_trap_en  in  1  1 = signed op; overflow traps.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback consumes head.
- out_result  out  DATA_WIDTH  head result.
- out_zero, out_carry, out_overflow  out  1 each  sanitised flags.
- out_dest  out  REG_ADDR_WIDTH  head destination.
- out_wen  out  1  register write enable for head.
- out_exc  out  1  head entry raised an overflow exception.
- exc_count  out  CNT_WIDTH  saturating count of accepted exception entries.
- exc_clr  in  1  clears exc_count.

Behaviour:
- Push: in_valid & in_ready. Pop: out_valid & out_ready. Storage is a 2-entry FIFO: wr_ptr, rd_ptr 1 bit each; count 0..2.
- in_ready is a register equal to (next count < 2), so it depends on state only, never combinationally on in_valid.
- out_valid = (count != 0). Outputs come from the head entry registers; no combinational path from in_* to out_*.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged. Legal only when count is 1; at count 2, in_ready = 0. At count 1 the old head leaves and the new entry becomes head next cycle.
- Pointers wrap modulo 2.
- Flag sanitisation at push:
  - AND/OR: carry = 0, overflow = 0.
  - ADD/SUB: pass through.
  - SLT: overflow = 0, carry passes through.
  - Undefined op codes: entry stored with wen = 0 and all flags 0.
- Zero is recomputed as (in_result == 0) rather than trusted from in_zero. A mismatch with in_zero is ignored.
- exc = in_trap_en & in_overflow & (op is ADD or SUB).
- wen = !exc & (in_dest != 0) & op defined.
- exc_count:
  - Increments on each push with exc = 1.
  - Saturates at all-ones.
  - exc_clr has priority over the increment in the same cycle and sets the count to 0.
- Reset (sync, rst = 1):
  - count = 0, pointers = 0, in_ready = 1 (valid from the first cycle after reset).
  - out_valid = 0, all out_* data/flags = 0, exc_count = 0.
  - In-flight entries are discarded; a push presented during the reset cycle is dropped.
- out_* hold stable while out_valid & !out_ready.
- Inputs are don't-care while in_valid = 0.

Decomposition:
- Shared package/header holds:
  - ALUop constants (AND, OR, ADD, SUB, SLT).
  - DATA_WIDTH and REG_ADDR_WIDTH defaults.
  - The entry field layout: result, zero, carry, overflow, dest, wen, exc.
- One natural sub-module, fifo2, a generic 2-entry valid/ready FIFO parameterised by payload width. The top level does flag sanitisation, exception decode and the counter, then packs the entry into the fifo2 payload.

Test Plan:
- Reset, then push ADD result 0x0000_0005, dest 3 → next cycle out_valid = 1, out_result = 0x5, out_zero = 0, out_wen = 1, in_ready = 1.
- Push ADD 0x7FFF_FFFF + 1 (result 0x8000_0000, overflow = 1, trap_en = 1), dest 4 → out_exc = 1, out_wen = 0, exc_count = 1; same with trap_en = 0 → out_wen = 1, out_exc = 0.
- out_ready = 0; push 3 back-to-back entries → first two accepted, in_ready = 0 after 2nd. Third held upstream; release out_ready → drained in order 1, 2, 3, one per cycle.
- AND 0xF0F0 & 0x0F0F with in_carryout = 1 and in_overflow = 1 injected → out_result = 0, out_zero = 1, out_carry = 0, out_overflow = 0; dest 0 → out_wen = 0.
- count = 1 with simultaneous push/pop for 10 cycles → out_valid stays 1, every entry seen exactly once. Assert rst mid-stream → next cycle out_valid = 0, exc_count = 0, in_ready = 1.
- Force exc_count to all-ones via 65535 trapping pushes, push another → stays 0xFFFF; exc_clr together with a trapping push → 0.

Source files
------------

// File: rtl/alu_result_buffer_pkg.sv
// Shared definitions for the ALU result buffer: ALUop encodings, default widths
// and the per-entry flag layout, plus the flag sanitisation helper.
package alu_result_buffer_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_CNT_WIDTH      = 16;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    // Entry layout is {result, dest, flags}; flags are packed in this order.
    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic wen;
        logic exc;
    } entry_flags_t;

    localparam int FLAG_WIDTH = $bits(entry_flags_t);

    function automatic entry_flags_t sanitise_flags(
        input logic [2:0] op,
        input logic       result_zero,
        input logic       carry,
        input logic       overflow,
        input logic       dest_nonzero,
        input logic       trap_en
    );
        entry_flags_t f;
        f = '0;
        case (op)
            OP_AND, OP_OR: begin
                f.zero = result_zero;
                f.wen  = dest_nonzero;
            end
            OP_ADD, OP_SUB: begin
                f.zero     = result_zero;
                f.carry    = carry;
                f.overflow = overflow;
                f.exc      = trap_en & overflow;
                f.wen      = !(trap_en & overflow) & dest_nonzero;
            end
            OP_SLT: begin
                f.zero  = result_zero;
                f.carry = carry;
                f.wen   = dest_nonzero;
            end
            default: begin
                f = '0;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu_result_buffer_fifo2.sv
// Generic 2-entry valid/ready FIFO with a registered push_ready and the head
// entry driven straight from storage registers.
module alu_result_buffer_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             push;
    logic             pop;

    assign push      = push_valid & push_ready;
    assign pop       = pop_valid & pop_ready;
    assign pop_valid = (count != 2'd0);
    assign pop_data  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // push_ready looks ahead at the next occupancy so it never depends on push_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            push_ready <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count      <= count_next;
            push_ready <= (count_next < 2'd2);
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Execute-to-writeback buffer: sanitises ALU flags, decodes overflow traps,
// queues entries in a 2-deep skid FIFO and counts exceptions for debug.
import alu_result_buffer_pkg::*;

module alu_result_buffer #(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_op,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic                      in_zero,
    input  logic                      in_overflow,
    input  logic                      in_carryout,
    input  logic [REG_ADDR_WIDTH-1:0] in_dest,
    input  logic                      in_trap_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic                      out_zero,
    output logic                      out_carry,
    output logic                      out_overflow,
    output logic [REG_ADDR_WIDTH-1:0] out_dest,
    output logic                      out_wen,
    output logic                      out_exc,
    output logic [CNT_WIDTH-1:0]      exc_count,
    input  logic                      exc_clr
);

    localparam int PAYLOAD_WIDTH = DATA_WIDTH + REG_ADDR_WIDTH + FLAG_WIDTH;

    logic [PAYLOAD_WIDTH-1:0] push_data;
    logic [PAYLOAD_WIDTH-1:0] pop_data;
    entry_flags_t             in_flags;
    entry_flags_t             out_flags;
    logic                     accepted;
    logic                     unused_in_zero;

    // The ALU's own Zero is not trusted; it is recomputed from the result.
    assign unused_in_zero = in_zero;

    assign in_flags = sanitise_flags(in_op, (in_result == '0), in_carryout,
                                     in_overflow, (in_dest != '0), in_trap_en);
    assign push_data = {in_result, in_dest, in_flags};
    assign accepted  = in_valid & in_ready;

    alu_result_buffer_fifo2 #(
        .WIDTH(PAYLOAD_WIDTH)
    ) u_fifo2 (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (push_data),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (pop_data)
    );

    assign {out_result, out_dest, out_flags} = pop_data;
    assign out_zero     = out_flags.zero;
    assign out_carry    = out_flags.carry;
    assign out_overflow = out_flags.overflow;
    assign out_wen      = out_flags.wen;
    assign out_exc      = out_flags.exc;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_count <= '0;
        end else if (exc_clr) begin
            exc_count <= '0;
        end else if (accepted && in_flags.exc && !(&exc_count)) begin
            exc_count <= exc_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed self-checking bench for alu_result_buffer with hand-computed expectations.
import alu_result_buffer_pkg::*;

module tb_alu_result_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_result;
    logic        in_zero;
    logic        in_overflow;
    logic        in_carryout;
    logic [4:0]  in_dest;
    logic        in_trap_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_carry;
    logic        out_overflow;
    logic [4:0]  out_dest;
    logic        out_wen;
    logic        out_exc;
    logic [15:0] exc_count;
    logic        exc_clr;

    int n_compared;
    int n_mismatched;

    alu_result_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_result    (in_result),
        .in_zero      (in_zero),
        .in_overflow  (in_overflow),
        .in_carryout  (in_carryout),
        .in_dest      (in_dest),
        .in_trap_en   (in_trap_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_dest     (out_dest),
        .out_wen      (out_wen),
        .out_exc      (out_exc),
        .exc_count    (exc_count),
        .exc_clr      (exc_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // in_zero is driven deliberately wrong so a design that trusts it is caught.
    task automatic applyStimulus(input logic valid, input logic [2:0] op,
                                 input logic [31:0] result, input logic ovf,
                                 input logic cout, input logic [4:0] dest,
                                 input logic trap);
        in_valid    = valid;
        in_op       = op;
        in_result   = result;
        in_zero     = (result != 32'd0);
        in_overflow = ovf;
        in_carryout = cout;
        in_dest     = dest;
        in_trap_en  = trap;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst       = 1'b1;
        out_ready = 1'b0;
        exc_clr   = 1'b0;
        applyStimulus(1'b1, OP_ADD, 32'h0000_0009, 1'b0, 1'b0, 5'd7, 1'b0);

        // Reset, with a push presented during reset that must be dropped.
        tick();
        tick();
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_exc_count", 64'(exc_count), 64'd0);
        checkOutput("rst_out_result", 64'(out_result), 64'd0);
        checkOutput("rst_out_wen", 64'(out_wen), 64'd0);
        rst = 1'b0;
        applyStimulus(1'b0, OP_ADD, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] basic ADD push");
        out_ready = 1'b1;
        applyStimulus(1'b1, OP_ADD, 32'h0000_0005, 1'b0, 1'b0, 5'd3, 1'b0);
        tick();
        applyStimulus(1'b0, OP_ADD, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("add_valid", 64'(out_valid), 64'd1);
        checkOutput("add_result", 64'(out_result), 64'h5);
        checkOutput("add_zero", 64'(out_zero), 64'd0);
        checkOutput("add_wen", 64'(out_wen), 64'd1);
        checkOutput("add_dest", 64'(out_dest), 64'd3);
        checkOutput("add_in_ready", 64'(in_ready), 64'd1);
        tick();
        checkOutput("add_drained", 64'(out_valid), 64'd0);

        $display("[TB] overflow trap and non-trap");
        applyStimulus(1'b1, OP_ADD, 32'h8000_0000, 1'b1, 1'b0, 5'd4, 1'b1);
        tick();
        applyStimulus(1'b0, OP_ADD, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("trap_exc", 64'(out_exc), 64'd1);
        checkOutput("trap_wen", 64'(out_wen), 64'd0);
        checkOutput("trap_exc_count", 64'(exc_count), 64'd1);
        tick();
        applyStimulus(1'b1, OP_ADD, 32'h8000_0000, 1'b1, 1'b0, 5'd4, 1'b0);
        tick();
        applyStimulus(1'b0, OP_ADD, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("notrap_exc", 64'(out_exc), 64'd0);
        checkOutput("notrap_wen", 64'(out_wen), 64'd1);
        checkOutput("notrap_ovf", 64'(out_overflow), 64'd1);
        checkOutput("notrap_exc_count", 64'(exc_count), 64'd1);
        tick();

        $display("[TB] flag sanitisation");
        applyStimulus(1'b1, OP_AND, 32'h0000_0000, 1'b1, 1'b1, 5'd0, 1'b1);
        tick();
        applyStimulus(1'b0, OP_ADD, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("and_result", 64'(out_result), 64'd0);
        checkOutput("and_zero", 64'(out_zero), 64'd1);
        checkOutput("and_carry", 64'(out_carry), 64'd0);
        checkOutput("and_ovf", 64'(out_overflow), 64'd0);
        checkOutput("and_wen", 64'(out_wen), 64'd0);
        checkOutput("and_exc", 64'(out_exc), 64'd0);
        tick();
        applyStimulus(1'b1, OP_SLT, 32'h0000_0001, 1'b1, 1'b1, 5'd5, 1'b1);
        tick();
        applyStimulus(1'b0, OP_ADD, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("slt_ovf", 64'(out_overflow), 64'd0);
        checkOutput("slt_carry", 64'(out_carry), 64'd1);
        checkOutput("slt_wen", 64'(out_wen), 64'd1);
        checkOutput("slt_exc", 64'(out_exc), 64'd0);
        tick();
        applyStimulus(1'b1, OP_SUB, 32'h0000_0000, 1'b0, 1'b1, 5'd6, 1'b1);
        tick();
        applyStimulus(1'b0, OP_ADD, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("sub_zero", 64'(out_zero), 64'd1);
        checkOutput("sub_carry", 64'(out_carry), 64'd1);
        checkOutput("sub_wen", 64'(out_wen), 64'd1);
        tick();
        applyStimulus(1'b1, 3'b011, 32'h0000_0007, 1'b1, 1'b1, 5'd2, 1'b1);
        tick();
        applyStimulus(1'b0, OP_ADD, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("undef_result", 64'(out_result), 64'h7);
        checkOutput("undef_wen", 64'(out_wen), 64'd0);
        checkOutput("undef_flags", 64'({out_zero, out_carry, out_overflow, out_exc}), 64'd0);
        checkOutput("undef_exc_count", 64'(exc_count), 64'd1);
        tick();

        $display("[TB] backpressure and ordered drain");
        out_ready = 1'b0;
        applyStimulus(1'b1, OP_OR, 32'h0000_0011, 1'b0, 1'b0, 5'd1, 1'b0);
        tick();
        checkOutput("bp_ready_after1", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, OP_OR, 32'h0000_0022, 1'b0, 1'b0, 5'd1, 1'b0);
        tick();
        checkOutput("bp_ready_after2", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, OP_OR, 32'h0000_0033, 1'b0, 1'b0, 5'd1, 1'b0);
        tick();
        tick();
        checkOutput("bp_held_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_held_head", 64'(out_result), 64'h11);
        out_ready = 1'b1;
        tick();
        checkOutput("drain_1", 64'(out_result), 64'h22);
        checkOutput("drain_ready", 64'(in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, OP_ADD, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("drain_2", 64'(out_result), 64'h33);
        checkOutput("drain_2_valid", 64'(out_valid), 64'd1);
        tick();
        checkOutput("drain_empty", 64'(out_valid), 64'd0);

        $display("[TB] streaming at count 1");
        applyStimulus(1'b1, OP_ADD, 32'd100, 1'b0, 1'b0, 5'd9, 1'b0);
        tick();
        checkOutput("stream_first", 64'(out_result), 64'd100);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, OP_ADD, 32'(100 + i), 1'b0, 1'b0, 5'd9, 1'b0);
            tick();
            checkOutput("stream_valid", 64'(out_valid), 64'd1);
            checkOutput("stream_result", 64'(out_result), 64'(100 + i));
        end
        rst = 1'b1;
        tick();
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_exc_count", 64'(exc_count), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        applyStimulus(1'b0, OP_ADD, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        checkOutput("midrst_dropped", 64'(out_valid), 64'd0);

        $display("[TB] exception counter saturation and clear");
        applyStimulus(1'b1, OP_ADD, 32'h8000_0000, 1'b1, 1'b0, 5'd1, 1'b1);
        repeat (65534) tick();
        checkOutput("sat_fffe", 64'(exc_count), 64'hFFFE);
        tick();
        checkOutput("sat_ffff", 64'(exc_count), 64'hFFFF);
        tick();
        checkOutput("sat_hold", 64'(exc_count), 64'hFFFF);
        exc_clr = 1'b1;
        tick();
        exc_clr = 1'b0;
        applyStimulus(1'b0, OP_ADD, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("clr_count", 64'(exc_count), 64'd0);
        checkOutput("clr_entry_exc", 64'(out_exc), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
